// File: rtl/bnn_pe_accum.sv
// bnn_pe_accum: binary (XNOR/popcount) processing element with a saturating
// signed accumulator, wrapped in an IDLE -> ACCUM -> DONE job controller.
//
// Ports
//   clk_in, rst_in            clock, async active-low reset
//   start_in, beats_in        job start pulse and beat count (0 counts as 1)
//   psum_in, threshold_in     initial accumulator / binarisation threshold
//   act_valid_in/ready_out    beat handshake; activation_in, weight_in data
//   activation_out            last accepted activation, forwarded downstream
//   out_valid_out/ready_in    result handshake
//   psum_out, sign_out        result and (psum >= threshold)
//   overflow_out              sticky saturation flag for the job
//   busy_out                  job in ACCUM or DONE
module bnn_pe_accum #(
    parameter int VEC_W  = 27,
    parameter int PSUM_W = 14,
    parameter int CNT_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [CNT_W-1:0]  beats_in,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic [PSUM_W-1:0] threshold_in,
    input  logic              act_valid_in,
    output logic              act_ready_out,
    input  logic [VEC_W-1:0]  activation_in,
    input  logic [VEC_W-1:0]  weight_in,
    output logic [VEC_W-1:0]  activation_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [PSUM_W-1:0] psum_out,
    output logic              sign_out,
    output logic              overflow_out,
    output logic              busy_out
);

    localparam int POP_W = $clog2(VEC_W + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state;
    logic signed [PSUM_W-1:0] acc;
    logic signed [PSUM_W-1:0] thr;
    logic [CNT_W-1:0]         cnt;

    logic [VEC_W-1:0]         match;
    logic [POP_W-1:0]         pop;
    logic signed [PSUM_W:0]   term;
    logic signed [PSUM_W:0]   sum;
    logic signed [PSUM_W-1:0] sum_sat;
    logic                     clamp;
    logic                     ge;
    logic                     accept;
    logic                     last_beat;

    // Per-bit XNOR: with the +1/-1 encoding a match contributes +1.
    genvar gi;
    generate
        for (gi = 0; gi < VEC_W; gi++) begin : g_lane
            assign match[gi] = ~(activation_in[gi] ^ weight_in[gi]);
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int i = 0; i < VEC_W; i++)
            pop = pop + POP_W'(match[i]);
    end

    // Dot product of +/-1 vectors: matches - mismatches = 2*pop - VEC_W.
    assign term = $signed((PSUM_W+1)'({pop, 1'b0})) - $signed((PSUM_W+1)'(VEC_W));
    assign sum  = {acc[PSUM_W-1], acc} + term;

    // One guard bit is enough: a disagreeing top pair means the sum left range.
    always_comb begin
        clamp   = sum[PSUM_W] ^ sum[PSUM_W-1];
        sum_sat = sum[PSUM_W-1:0];
        if (clamp)
            sum_sat = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                  : {1'b0, {(PSUM_W-1){1'b1}}};
    end

    assign ge        = (sum_sat >= thr);
    assign accept    = act_valid_in && (state == ACCUM);
    assign last_beat = (cnt == CNT_W'(1));

    assign act_ready_out = (state == ACCUM);
    assign out_valid_out = (state == DONE);
    assign busy_out      = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            acc            <= '0;
            thr            <= '0;
            cnt            <= '0;
            activation_out <= '0;
            psum_out       <= '0;
            sign_out       <= 1'b0;
            overflow_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        cnt          <= (beats_in == '0) ? CNT_W'(1) : beats_in;
                        acc          <= psum_in;
                        thr          <= threshold_in;
                        overflow_out <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc            <= sum_sat;
                        activation_out <= activation_in;
                        cnt            <= cnt - CNT_W'(1);
                        if (clamp)
                            overflow_out <= 1'b1;
                        // Result registers only move at job end so they
                        // hold through DONE and into the following IDLE.
                        if (last_beat) begin
                            psum_out <= sum_sat;
                            sign_out <= ge;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_pe_accum.sv
module tb_bnn_pe_accum;

    localparam int VEC_W  = 27;
    localparam int PSUM_W = 14;
    localparam int CNT_W  = 8;
    localparam int PMAX   = 2**(PSUM_W-1) - 1;
    localparam int PMIN   = -(2**(PSUM_W-1));

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  beats;
    logic [PSUM_W-1:0] psum_i;
    logic [PSUM_W-1:0] thr_i;
    logic              act_valid;
    logic              act_ready;
    logic [VEC_W-1:0]  act;
    logic [VEC_W-1:0]  wt;
    logic [VEC_W-1:0]  act_o;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] psum_o;
    logic              sign_o;
    logic              ovf_o;
    logic              busy;

    bnn_pe_accum #(.VEC_W(VEC_W), .PSUM_W(PSUM_W), .CNT_W(CNT_W)) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start), .beats_in(beats),
        .psum_in(psum_i), .threshold_in(thr_i), .act_valid_in(act_valid),
        .act_ready_out(act_ready), .activation_in(act), .weight_in(wt),
        .activation_out(act_o), .out_valid_out(out_valid), .out_ready_in(out_ready),
        .psum_out(psum_o), .sign_out(sign_o), .overflow_out(ovf_o), .busy_out(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int psum;
        int sign;
        int ovf;
    } exp_t;

    exp_t             sb[$];
    int               checks;
    int               errors;
    logic [VEC_W-1:0] jact[0:15];
    logic [VEC_W-1:0] jwt[0:15];
    int               exp_psum, exp_sign, exp_ovf;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: signed dot product of +/-1 vectors, clamped after every beat.
    task automatic model_job(input int nbeats, input int psum, input int thr);
        int n, a, pc;
        n = (nbeats == 0) ? 1 : nbeats;
        a = psum;
        exp_ovf = 0;
        for (int b = 0; b < n; b++) begin
            pc = $countones(~(jact[b] ^ jwt[b]));
            a = a + 2 * pc - VEC_W;
            if (a > PMAX) begin a = PMAX; exp_ovf = 1; end
            if (a < PMIN) begin a = PMIN; exp_ovf = 1; end
        end
        exp_psum = a;
        exp_sign = (a >= thr) ? 1 : 0;
    endtask

    // Monitor: every result handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got psum %0d expected no result", $signed(psum_o));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_psum", $signed(psum_o), e.psum);
                chk("sb_sign", int'(sign_o), e.sign);
                chk("sb_ovf", int'(ovf_o), e.ovf);
            end
        end
    end

    task automatic run_job(input int nbeats, input int psum, input int thr,
                           input int gap, input int hold);
        int   n, to;
        exp_t e;
        n = (nbeats == 0) ? 1 : nbeats;
        model_job(nbeats, psum, thr);
        e.psum = exp_psum; e.sign = exp_sign; e.ovf = exp_ovf;
        sb.push_back(e);

        @(posedge clk); #1;
        start = 1'b1; beats = nbeats[CNT_W-1:0];
        psum_i = psum[PSUM_W-1:0]; thr_i = thr[PSUM_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        chk("ready_in_accum", int'(act_ready), 1);
        @(posedge clk); #1;

        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap; g++) begin
                act_valid = 1'b0; act = $urandom; wt = $urandom;
                @(posedge clk); #1;
            end
            act_valid = 1'b1; act = jact[b]; wt = jwt[b];
            to = 0;
            @(negedge clk);
            while (!act_ready && to < 50) begin to++; @(negedge clk); end
            if (to >= 50) chk("accept_timeout", 0, 1);
            chk("valid_before_last", int'(out_valid), 0);
            @(posedge clk); #1;
            act_valid = 1'b0;
        end

        // One cycle after the final accept.
        chk("latency_valid", int'(out_valid), 1);
        chk("ready_in_done", int'(act_ready), 0);
        chk("act_forward", int'(act_o), int'(jact[n-1]));

        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin start = 1'b1; beats = 8'd5; end
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_psum", $signed(psum_o), exp_psum);
            chk("hold_sign", int'(sign_o), exp_sign);
            chk("hold_ovf", int'(ovf_o), exp_ovf);
            chk("hold_ready", int'(act_ready), 0);
            @(posedge clk); #1;
            start = 1'b0;
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", int'(out_valid), 0);
        chk("idle_busy", int'(busy), 0);
        chk("psum_held", $signed(psum_o), exp_psum);
        chk("sign_held", int'(sign_o), exp_sign);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psum"}, int'(psum_o), 0);
        chk({tag, "_act"}, int'(act_o), 0);
        chk({tag, "_sign"}, int'(sign_o), 0);
        chk({tag, "_ovf"}, int'(ovf_o), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_ready"}, int'(act_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nb, ps, th;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; beats = '0; psum_i = '0; thr_i = '0;
        act_valid = 1'b0; act = '0; wt = '0; out_ready = 1'b0;
        #23;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single all-match beat: 0 + 27.
        jact[0] = '1; jwt[0] = '1;
        run_job(1, 0, 0, 0, 0);

        // Three all-mismatch beats from 5, result held 5 cycles with a stray start.
        for (int b = 0; b < 3; b++) begin jact[b] = '1; jwt[b] = '0; end
        run_job(3, 5, 0, 0, 5);

        // Saturation at both ends.
        for (int b = 0; b < 2; b++) begin jact[b] = '1; jwt[b] = '1; end
        run_job(2, 8190, 0, 0, 0);
        for (int b = 0; b < 2; b++) begin jact[b] = '0; jwt[b] = '1; end
        run_job(2, -8190, 0, 0, 1);

        // beats=0 acts as one beat, with and without input gaps.
        jact[0] = 27'h2AB_CDEF; jwt[0] = 27'h2AB_CDEF;
        run_job(0, 100, 127, 0, 0);
        run_job(0, 100, 128, 3, 2);

        // Reset after one of three beats: everything clears, no result appears.
        @(posedge clk); #1;
        start = 1'b1; beats = 8'd3; psum_i = 14'd10; thr_i = '0;
        @(posedge clk); #1;
        start = 1'b0; act_valid = 1'b1; act = 27'h5A5_A5A5; wt = 27'h0F0_F0F0;
        @(posedge clk); #1;
        act_valid = 1'b0;
        chk("mid_act_forward", int'(act_o), 27'h5A5_A5A5);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_reset_idle", int'(busy) + int'(out_valid), 0);
        end
        for (int b = 0; b < 4; b++) begin jact[b] = $urandom; jwt[b] = $urandom; end
        run_job(4, -300, -400, 1, 0);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            nb = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0)
                ps = ($urandom_range(0, 1) == 1) ? PMAX - int'($urandom_range(0, 60))
                                                 : PMIN + int'($urandom_range(0, 60));
            else
                ps = int'($urandom_range(0, 4000)) - 2000;
            th = int'($urandom_range(0, 800)) - 400;
            for (int b = 0; b < 16; b++) begin
                jact[b] = $urandom;
                jwt[b]  = ($urandom_range(0, 3) == 0) ? jact[b] : VEC_W'($urandom);
            end
            run_job(nb, ps, th, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_pe_accum.md
BNN_PE_ACCUM -- requirements
Module: bnn_pe_accum

Interface
REQ-001 Parameter VEC_W, default 27: binary activation/weight vector width per beat.
REQ-002 Parameter PSUM_W, default 14: signed partial-sum width.
REQ-003 Parameter CNT_W, default 8: beat-count width.
REQ-004 clk_in  input  1  single clock, all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 start_in  input  1  pulse; begins a new accumulation job when IDLE.
REQ-007 beats_in  input  CNT_W  number of vector beats in the job, sampled with start_in.
REQ-008 psum_in  input  PSUM_W  signed initial accumulator value, sampled with start_in.
REQ-009 threshold_in  input  PSUM_W  signed binarisation threshold, sampled with start_in.
REQ-010 act_valid_in  input  1  activation/weight beat valid.
REQ-011 act_ready_out  output  1  block accepts a beat.
REQ-012 activation_in  input  VEC_W  binary activations (1 = +1, 0 = -1).
REQ-013 weight_in  input  VEC_W  binary weights, same encoding.
REQ-014 activation_out  output  VEC_W  registered copy of last accepted activation, for the downstream PE.
REQ-015 out_valid_out  output  1  result valid.
REQ-016 out_ready_in  input  1  downstream accepts result.
REQ-017 psum_out  output  PSUM_W  signed accumulated result.
REQ-018 sign_out  output  1  1 when psum_out >= latched threshold (signed), else 0.
REQ-019 overflow_out  output  1  sticky saturation flag for the current job.
REQ-020 busy_out  output  1  high in ACCUM or DONE.

Function
REQ-021 FSM states IDLE, ACCUM, DONE; IDLE after reset.
REQ-022 IDLE: start_in=1 -> latch beats_in (0 treated as 1), psum_in into accumulator, threshold_in; clear overflow; go ACCUM next cycle.
REQ-023 start_in in ACCUM or DONE is ignored, no state change.
REQ-024 act_ready_out = 1 only in ACCUM; beat accepted on cycle with act_valid_in & act_ready_out.
REQ-025 Per accepted beat: pop = count of bits where activation_in XNOR weight_in; term = 2*pop - VEC_W, signed, range [-VEC_W, +VEC_W].
REQ-026 Accumulator <= acc + term in the accept cycle, computed at PSUM_W+1 bits, saturated to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; any clamp sets overflow_out until next start.
REQ-027 activation_out updates to activation_in on each accepted beat only; holds otherwise.
REQ-028 Beat counter decrements per accepted beat; accepting the final beat moves FSM to DONE next cycle.
REQ-029 DONE: out_valid_out=1; psum_out, sign_out, overflow_out stable while out_ready_in=0.
REQ-030 DONE with out_ready_in=1 -> IDLE next cycle; out_valid_out deasserts; psum_out/sign_out hold last value.
REQ-031 Latency: out_valid_out rises exactly 1 cycle after final beat accepted; minimum job start-to-valid = beats+1 cycles with act_valid_in held high.
REQ-032 act_valid_in gaps in ACCUM stall the job indefinitely with no state loss.

Reset
REQ-033 rst_in low, regardless of clock: FSM -> IDLE; psum_out, activation_out, accumulator, counter, threshold = 0; sign_out, overflow_out, out_valid_out, act_ready_out, busy_out = 0.
REQ-034 Reset mid-job discards the job; no result is produced after release.

Verification (VEC_W=27, PSUM_W=14)
REQ-035 start beats=1 psum=0 thr=0; act=weight=all-ones -> psum_out=27, sign_out=1, out_valid 1 cycle after accept.
REQ-036 start beats=3 psum=5 thr=0; act=all-ones, weight=0 x3 -> psum_out=-76, sign_out=0, overflow_out=0.
REQ-037 Result ready, out_ready_in low 5 cycles -> outputs held, act_ready_out=0, start_in ignored; then ready=1 -> IDLE next cycle.
REQ-038 psum=8190, beats=2, all-match -> psum_out=8191, overflow_out=1; psum=-8190, all-mismatch -> -8192, overflow_out=1.
REQ-039 rst_in low after 1 of 3 beats -> all outputs 0 immediately, IDLE; new job after release correct.
REQ-040 beats_in=0 with one matching beat -> behaves as beats=1, psum_out=psum_in+27; act_valid_in gaps of 3 cycles -> same result, delayed.
